// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit add through one 4-bit CLA slice, LSB nibble first; CLA_SEQ_SUB_EN adds in_sub (A + ~B + 1).
// Latency NIBBLES edges from accept to out_valid; out_* held while out_ready is low, in_ready low until result consumed.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept, last;
  logic [3:0]       nib_a, nib_b, p, g, nib_s;
  logic [4:0]       c;

  // Subtraction is folded in at accept time so the slice itself stays add-only.
`ifdef CLA_SEQ_SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  always_comb begin
    nib_a = a_q[{idx, 2'b00} +: 4];
    nib_b = b_q[{idx, 2'b00} +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_s = p ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
          end
        end
        BUSY: begin
          out_sum[{idx, 2'b00} +: 4] <= nib_s;
          carry <= c[4];
          if (last) begin
            idx      <= '0;
            out_cout <= c[4];
            out_ovf  <= c[3] ^ c[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed-vector bench for cla_seq_adder_ctrl: WIDTH=16 main instance plus a WIDTH=4 instance.
module tb_cla_seq_adder_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_cout, out_ovf, busy;
  logic [W-1:0] out_sum;

  logic         v4 = 1'b0, ordy4 = 1'b0;
  logic [3:0]   a4 = '0, b4 = '0;
  logic         irdy4, ovld4, cout4, ovf4, busy4;
  logic [3:0]   sum4;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  cla_seq_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(irdy4),
    .in_a(a4), .in_b(b4), .in_cin(1'b0),
`ifdef CLA_SEQ_SUB_EN
    .in_sub(1'b0),
`endif
    .out_valid(ovld4), .out_ready(ordy4), .out_sum(sum4),
    .out_cout(cout4), .out_ovf(ovf4), .busy(busy4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".sum"}, 32'(out_sum), 32'(es));
    check({tag, ".cout"}, 32'(out_cout), 32'(ec));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum", 32'(out_sum), 32'd0);
    check("rst.cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    do_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("8000x2", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("cin_00ff", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("ffffx2_c", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result held in DONE while new operands are presented.
    check("bp.in_ready", 32'(in_ready), 32'd1);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'hAAAA; in_b = 16'h5555;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.sum", 32'(out_sum), 32'h3333);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.valid_drop", 32'(out_valid), 32'd0);
    check("bp.ready_back", 32'(in_ready), 32'd1);
    check("bp.sum_hold", 32'(out_sum), 32'h3333);

    // Reset on the second BUSY cycle of 0xFFFF+0xFFFF.
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy), 32'd1);
    check("abort.nib0", 32'(out_sum[3:0]), 32'hE);
    rst_n = 1'b0;
    #1;
    check("abort.busy_clr", 32'(busy), 32'd0);
    check("abort.sum_clr", 32'(out_sum), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // WIDTH=4: single BUSY cycle, 0x9+0x8 wraps with signed overflow.
    check("w4.in_ready", 32'(irdy4), 32'd1);
    a4 = 4'h9; b4 = 4'h8; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    check("w4.busy_cycle", 32'(ovld4), 32'd0);
    @(posedge clk); #1;
    check("w4.valid", 32'(ovld4), 32'd1);
    check("w4.sum", 32'(sum4), 32'h1);
    check("w4.cout_ovf", {30'd0, cout4, ovf4}, 32'd3);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
    check("w4.valid_drop", 32'(ovld4), 32'd0);

`ifdef CLA_SEQ_SUB_EN
    do_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
